// File: rtl/mul_pkg.sv
// mul_pkg: shared constants for the integer multiply execution unit.
//   XLEN         operand width (only 32 is supported)
//   MUL_LATENCY  register stages from accept to result
//   mul_op_e     RISC-V funct3[1:0] multiply encodings
package mul_pkg;

    localparam int XLEN        = 32;
    localparam int MUL_LATENCY = 3;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    // rs1 is treated as two's complement for MULH and MULHSU
    function automatic logic rs1_signed(input logic [1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    // rs2 is treated as two's complement for MULH only
    function automatic logic rs2_signed(input logic [1:0] op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul32x32.sv
// mul32x32: purely combinational unsigned 32x32 -> 64 array multiplier.
//   i_a, i_b : 32-bit unsigned operands
//   o_p      : 64-bit unsigned product
module mul32x32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_p
);

    logic [63:0] w_acc;

    // One gated partial-product row per multiplier bit, summed down the array.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < 32; i++) begin
            w_acc = w_acc + ({32'b0, i_b & {32{i_a[i]}}} << i);
        end
    end

    assign o_p = w_acc;

endmodule

// File: rtl/mul_exec_unit.sv
// mul_exec_unit: 3-stage pipelined RISC-V M-extension multiplier
// (MUL/MULH/MULHSU/MULHU) with valid/ready handshake and flush.
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        request handshake
//   in_op, in_rs1, in_rs2    operation and operands
//   in_tag                   destination tag, returned with the result
//   flush                    kill everything in flight
//   out_valid/out_ready      result handshake
//   out_result, out_tag      result and its tag
//   busy                     any stage holds a valid operation
module mul_exec_unit
    import mul_pkg::*;
#(
    parameter int XLEN  = mul_pkg::XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // stage valids
    logic r_v1, r_v2, r_v3;

    // S1: operands
    logic [1:0]       r_op1;
    logic [XLEN-1:0]  r_rs1, r_rs2;
    logic [TAG_W-1:0] r_tag1;

    // S2: raw product plus summed sign correction
    logic [1:0]        r_op2;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_corr;
    logic [TAG_W-1:0]  r_tag2;

    // S3: final result
    logic [XLEN-1:0]  r_res3;
    logic [TAG_W-1:0] r_tag3;

    logic              w_adv;
    logic              w_accept;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_corr;

    // The whole pipe moves in lockstep: it only stalls when the output is full and unaccepted.
    assign w_adv    = !r_v3 || out_ready;
    assign in_ready = w_adv && !flush;
    assign w_accept = in_valid && in_ready;

    mul32x32 u_mul (
        .i_a (r_rs1),
        .i_b (r_rs2),
        .o_p (w_prod)
    );

    // Signed high word = unsigned high word minus the other operand for each
    // negative signed input; both terms are pre-summed so S3 does one subtract.
    assign w_corr = ((rs1_signed(r_op1) && r_rs1[XLEN-1]) ? r_rs2 : '0)
                  + ((rs2_signed(r_op1) && r_rs2[XLEN-1]) ? r_rs1 : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1  <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_tag1 <= '0;
            r_op2  <= '0;
            r_prod <= '0;
            r_corr <= '0;
            r_tag2 <= '0;
            r_res3 <= '0;
            r_tag3 <= '0;
        end else begin
            if (w_accept) begin
                r_op1  <= in_op;
                r_rs1  <= in_rs1;
                r_rs2  <= in_rs2;
                r_tag1 <= in_tag;
            end
            if (w_adv && r_v1) begin
                r_op2  <= r_op1;
                r_prod <= w_prod;
                r_corr <= w_corr;
                r_tag2 <= r_tag1;
            end
            if (w_adv && r_v2) begin
                r_res3 <= (r_op2 == OP_MUL) ? r_prod[XLEN-1:0]
                                            : r_prod[2*XLEN-1:XLEN] - r_corr;
                r_tag3 <= r_tag2;
            end
        end
    end

    assign out_valid  = r_v3;
    assign out_result = r_res3;
    assign out_tag    = r_tag3;
    assign busy       = r_v1 || r_v2 || r_v3;

endmodule

// File: tb/tb_mul_exec_unit.sv
module tb_mul_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_exec_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // step to 1ns after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single op into an empty pipe with out_ready high. Called at posedge+1.
    // The accept edge is the first of three register loads; out_valid must
    // show after the third edge and not before.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tg;
        #1;
        chk({nm, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        chk({nm, ".ov_e1"}, {31'b0, out_valid}, 32'd0);
        chk({nm, ".busy"}, {31'b0, busy}, 32'd1);
        cyc();
        chk({nm, ".ov_e2"}, {31'b0, out_valid}, 32'd0);
        cyc();
        chk({nm, ".ov_e3"}, {31'b0, out_valid}, 32'd1);
        chk({nm, ".result"}, out_result, exp);
        chk({nm, ".tag"}, {27'b0, out_tag}, {27'b0, tg});
        cyc();
        chk({nm, ".drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    logic [1:0]  s_op  [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [31:0] s_a   [4] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] s_b   [4] = '{32'd6, 32'hFFFFFFFF, 32'h80000000, 32'h00000002};
    logic [4:0]  s_tag [4] = '{5'd3, 5'd4, 5'd5, 5'd6};
    logic [31:0] s_exp [4] = '{32'h0000002A, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF};

    initial begin
        int iss;
        int got;
        logic [31:0] held;
        logic [4:0]  held_tag;
        logic        held_v;

        // reset state
        #2;
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.out_result", out_result, 32'd0);
        chk("rst.out_tag", {27'b0, out_tag}, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        cyc();

        // directed single ops
        run_op("mul7x6",     2'b00, 32'd7,        32'd6,        5'd3,  32'h0000002A);
        run_op("mulhu_m1",   2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE);
        run_op("mulh_m1",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000);
        run_op("mulh_min",   2'b01, 32'h80000000, 32'h80000000, 5'd17, 32'h40000000);
        run_op("mulhsu_neg", 2'b10, 32'hFFFFFFFF, 32'h00000002, 5'd9,  32'hFFFFFFFF);
        run_op("mulhsu_pos", 2'b10, 32'h00000002, 32'hFFFFFFFF, 5'd31, 32'h00000001);
        run_op("mul_low",    2'b00, 32'h12345678, 32'h00000010, 5'd8,  32'h23456780);

        // back-to-back stream with a 5-cycle consumer stall
        iss = 0; got = 0; held_v = 1'b0; held = '0; held_tag = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            out_ready = !(c >= 3 && c < 8);
            in_valid  = (iss < 4);
            if (iss < 4) begin
                in_op = s_op[iss]; in_rs1 = s_a[iss]; in_rs2 = s_b[iss]; in_tag = s_tag[iss];
            end
            #1;
            if (out_valid && !out_ready) begin
                chk("stall.in_ready", {31'b0, in_ready}, 32'd0);
                if (held_v) begin
                    chk("stall.result_stable", out_result, held);
                    chk("stall.tag_stable", {27'b0, out_tag}, {27'b0, held_tag});
                end
                held = out_result; held_tag = out_tag; held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("stream.result", out_result, s_exp[got]);
                chk("stream.tag", {27'b0, out_tag}, {27'b0, s_tag[got]});
                got++;
            end
            if (in_valid && in_ready) iss++;
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream.count", got, 32'd4);
        #1;
        chk("stream.no_dup", {31'b0, out_valid}, 32'd0);
        cyc();

        // flush with three ops in flight; request in flush cycle is refused
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd100 + k; in_rs2 = 32'd2; in_tag = 5'(k);
            cyc();
        end
        chk("flush.pre_busy", {31'b0, busy}, 32'd1);
        chk("flush.pre_ov", {31'b0, out_valid}, 32'd1);
        flush = 1'b1; in_rs1 = 32'd55;
        #1;
        chk("flush.in_ready", {31'b0, in_ready}, 32'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush.busy", {31'b0, busy}, 32'd0);
        cyc(); cyc(); cyc();
        chk("flush.no_stale", {31'b0, out_valid}, 32'd0);
        run_op("post_flush", 2'b11, 32'h00000002, 32'hFFFFFFFF, 5'd12, 32'h00000001);

        // asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd9; in_rs2 = 32'd9 + k; in_tag = 5'd20 + 5'(k);
            cyc();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst.busy", {31'b0, busy}, 32'd0);
        chk("arst.out_result", out_result, 32'd0);
        chk("arst.out_tag", {27'b0, out_tag}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("arst.in_ready", {31'b0, in_ready}, 32'd1);
        cyc(); cyc(); cyc();
        chk("arst.no_stale", {31'b0, out_valid}, 32'd0);
        run_op("mul3x5", 2'b00, 32'd3, 32'd5, 5'd7, 32'h0000000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_exec_unit.md
MUL_EXEC_UNIT -- requirements
Module: mul_exec_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand width; only 32 is supported.
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning destination-register tag width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: request accepted this cycle when in_valid is also high.
REQ-007 The block SHALL have port in_op, input, 2 bits: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RISC-V funct3[1:0]).
REQ-008 The block SHALL have ports in_rs1 and in_rs2, input, XLEN bits each: operands.
REQ-009 The block SHALL have port in_tag, input, TAG_W bits: destination tag, returned unchanged.
REQ-010 The block SHALL have port flush, input, 1 bit: kill all in-flight operations.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have ports out_result (XLEN bits) and out_tag (TAG_W bits), both outputs.
REQ-014 The block SHALL have port busy, output, 1 bit: high while any stage holds a valid operation.

Function
REQ-015 Pipeline: S1 registers operands, op and tag; the unsigned 64-bit product is formed combinationally from the S1 registers; S2 registers the product and the correction terms; S3 registers the final result.
REQ-016 Latency: an accepted request SHALL produce out_valid exactly 3 cycles after the accept edge when there is no back-pressure; throughput is 1 per cycle.
REQ-017 Advance enable: adv = !out_valid || out_ready. All stages SHALL hold when adv is low; in_ready = adv.
REQ-018 Signed correction: hi = P[63:32] - (rs1[31] && rs1 is signed ? rs2 : 0) - (rs2[31] && rs2 is signed ? rs1 : 0), mod 2^32.
REQ-019 Signedness: rs1 is signed for MULH and MULHSU; rs2 is signed for MULH only.
REQ-020 Result selection: MUL returns P[31:0] with no correction; the other ops return the corrected hi.
REQ-021 out_result and out_tag SHALL remain stable while out_valid is high and out_ready is low.
REQ-022 flush SHALL clear all stage valid bits at the next edge, including the output stage; an in_valid request in the flush cycle SHALL NOT be accepted (in_ready forced low).
REQ-023 If flush and out_ready are high together, the output SHALL be dropped and no transfer is counted.
REQ-024 busy = OR of the S1, S2 and S3 valid bits.
REQ-025 Data registers SHALL load only when adv is high and the upstream stage is valid; bubbles SHALL NOT disturb held data.

Reset
REQ-026 During rst: all valid bits 0, so out_valid=0 and busy=0; out_result=0; out_tag=0; in_ready=1 after rst deasserts.
REQ-027 A reset mid-operation SHALL discard in-flight operations, and no stale out_valid SHALL appear after release.

Structure
REQ-028 Shared package mul_pkg SHALL hold the XLEN constant, the MUL_LATENCY=3 constant, and the op encodings OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU.
REQ-029 The block SHALL instantiate exactly one sub-module, the existing unsigned array multiplier mul32x32, between S1 and S2; no other multiplier logic is permitted.

Verification
REQ-030 MUL 7 x 6, tag 3 -> out_result 0x0000002A, out_tag 3, exactly 3 cycles after accept.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-032 MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MULHSU 0x00000002 x 0xFFFFFFFF -> 0x00000001.
REQ-033 Back-to-back stream of 4 ops with out_ready low for 5 cycles mid-stream -> in order, no loss or duplication, result held stable, in_ready low during the stall.
REQ-034 flush with 3 ops in flight -> out_valid=0 and busy=0 next cycle; next op's result is correct with no stale data.
REQ-035 rst asserted asynchronously mid-stream -> outputs zero immediately; after release, a new MUL 3 x 5 -> 0x0000000F.
